work_dispatcher: RTL and testbench
==================================

Name: work_dispatcher

Overview:
Hands out search-range chunks to the jimmy cores: the outbound counterpart to the result collection in the multicore top, feeding each core's lower/upper bound inputs instead of collecting its outputs.
- A core raises its request; the dispatcher picks one core per cycle by round-robin and returns a registered [lo, hi] chunk with a one-cycle ack.
- Once the global range is used up, every ack carries an empty flag.

Parameters:
CORES, 4, number of requesting cores (1..8)
ADDR_W, 8, width of bound values
RANGE_LO, 0, first value of the global range
RANGE_HI, 255, last value of the global range (inclusive, RANGE_HI >= RANGE_LO)
CHUNK, 16, values per chunk (>= 1)

Ports:
clk  input  1  system clock (the single clock)
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins dispatch of the range
req  input  CORES  per-core level request for a chunk
ack  output  CORES  per-core one-cycle grant pulse; lo/hi/empty valid while high
lo_out  output  CORES*ADDR_W  per-core chunk lower bound, packed, core i at [i*ADDR_W +: ADDR_W]
hi_out  output  CORES*ADDR_W  per-core chunk upper bound, same packing
empty  output  CORES  per-core flag: ack carried no work
busy  output  1  high from start until the range is exhausted
done  output  1  high once the range is exhausted; held until reset
chunks_issued  output  8  count of non-empty acks, saturating at 255

Behaviour:
- Reset is asynchronous and active-low (reset=0). It clears all outputs and all state: ack/empty/lo_out/hi_out/busy/done/chunks_issued = 0, FSM = IDLE, rr pointer = 0, next_lo = RANGE_LO. Reset mid-run aborts immediately; nothing is retained.
- FSM states:
  - IDLE: req ignored; ack stays 0. start -> RUN, next_lo = RANGE_LO, busy = 1.
  - RUN: dispatching chunks; start ignored.
  - DONE: busy = 0, done = 1; start ignored.
- Arbitration in RUN/DONE:
  - Eligible cores are req[i]=1 AND ack[i]=0. A request seen on the cycle its own ack is high is not re-granted, so the core has that cycle to drop req.
  - Winner is the first eligible index at or after the rr pointer, wrapping. After a grant to core i, pointer = (i+1) mod CORES.
  - At most one grant per cycle.
- Latency: req sampled at edge N -> ack[i] high during cycle N+1, lo/hi/empty for core i updated at the same edge. ack is a single-cycle pulse. lo_out/hi_out hold their last value until core i's next grant.
- Chunk arithmetic:
  - Computed in ADDR_W+1 bits.
  - hi = min(next_lo + CHUNK - 1, RANGE_HI).
  - next_lo <= hi + 1.
  - When hi == RANGE_HI the range is exhausted: FSM -> DONE on the same edge as that grant. next_lo never wraps to 0, including the case RANGE_HI = 2^ADDR_W - 1.
- DONE: eligible requests are still granted round-robin, with ack[i]=1, empty[i]=1 and lo/hi unchanged. chunks_issued does not advance.
- chunks_issued increments by 1 on every non-empty grant and saturates at 255.
- Simultaneous events:
  - start arriving in the same cycle as req: the req is first eligible on the next cycle.
  - The last chunk and other pending requests in one cycle: only the winner gets the last chunk; the others receive empty acks on later cycles.

Decomposition:
- Package multicore_pkg:
  - dispatch_state_t enum {IDLE, RUN, DONE}
  - CORES_MAX = 8
  - helper function for packed-slice indexing
- One sub-module, rr_arbiter. Parameter N. Inputs: request vector, pointer. Outputs: one-hot grant, grant index, any-grant. Purely combinational.
- The FSM, chunk datapath and output registers live in work_dispatcher.

Test Plan:
1. Hold reset=0 and toggle clk; deassert reset -> all outputs 0; req=4'b1111 without start produces no ack.
2. start, then req=4'b0001 held one cycle -> ack=4'b0001 next cycle with lo0=0, hi0=15; second request -> lo0=16, hi0=31; chunks_issued=2.
3. start, then req=4'b1111 held, each core dropping req after its ack -> acks to cores 0,1,2,3 on consecutive cycles with chunks 0-15, 16-31, 32-47, 48-63. A second all-request then starts again at core 0 with 64-79.
4. RANGE_HI=250, repeated requests from core 2 -> 16th chunk is 240..250, done=1, busy=0, chunks_issued=16; next request -> ack[2]=1, empty[2]=1, lo/hi unchanged.
5. RANGE_HI=255, ADDR_W=8 -> last chunk 240..255 then DONE; no chunk 0..15 ever reissued (no wrap).
6. Assert reset=0 mid-grant with chunks_issued=5 -> all outputs 0 asynchronously before the next edge; after release, start re-issues from 0..15.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared types and helpers for the multicore search fabric.
// Used by the work dispatcher and its round-robin arbiter.
package multicore_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dispatch_state_t;

  localparam int CORES_MAX = 8;

  function automatic int slice_lsb(
    input int idx,
    input int w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/work_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_c;

  // Scan farthest-first so the nearest request overwrites.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_c = (int'(i_ptr) + k) % N;
      if (i_req[w_c]) begin
        o_idx = PW'(w_c);
        o_any = 1'b1;
      end
    end
    o_gnt[o_idx] = o_any;
  end

endmodule

// File: rtl/work_dispatcher.sv
// Hands out [lo, hi] search chunks to requesting cores.
// One round-robin grant per cycle; empty acks once exhausted.
module work_dispatcher
  import multicore_pkg::*;
#(
  parameter int CORES    = 4,
  parameter int ADDR_W   = 8,
  parameter int RANGE_LO = 0,
  parameter int RANGE_HI = 255,
  parameter int CHUNK    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CORES-1:0]        req,
  output logic [CORES-1:0]        ack,
  output logic [CORES*ADDR_W-1:0] lo_out,
  output logic [CORES*ADDR_W-1:0] hi_out,
  output logic [CORES-1:0]        empty,
  output logic                    busy,
  output logic                    done,
  output logic [7:0]              chunks_issued
);

  localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;
  localparam int CW = ADDR_W + 1;
  localparam int CH = (CHUNK > (1 << ADDR_W)) ?
                      (1 << ADDR_W) : CHUNK;

  localparam logic [CW-1:0] C_LO   = CW'(RANGE_LO);
  localparam logic [CW-1:0] C_HI   = CW'(RANGE_HI);
  localparam logic [CW-1:0] C_STEP = CW'(CH - 1);

  dispatch_state_t r_state;
  dispatch_state_t w_state_nxt;

  logic [PW-1:0]     r_ptr;
  logic [CW-1:0]     r_next_lo;
  logic [CORES-1:0]  r_ack;
  logic [CORES-1:0]  r_empty;
  logic [ADDR_W-1:0] r_lo [CORES];
  logic [ADDR_W-1:0] r_hi [CORES];
  logic [7:0]        r_cnt;

  logic [CORES-1:0] w_elig;
  logic [CORES-1:0] w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  logic             w_grant;
  logic             w_work;
  logic             w_last;
  logic [CW-1:0]    w_sum;
  logic [CW-1:0]    w_hi;

  // A core still seeing its own ack gets a cycle to drop req.
  assign w_elig = req & ~r_ack;

  rr_arbiter #(
    .N  (CORES),
    .PW (PW)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_grant = w_any && (r_state != IDLE);
  assign w_work  = w_grant && (r_state == RUN);
  assign w_sum   = r_next_lo + C_STEP;
  assign w_hi    = (w_sum > C_HI) ? C_HI : w_sum;
  assign w_last  = w_work && (w_hi == C_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_next_lo <= C_LO;
      r_ack     <= '0;
      r_empty   <= '0;
      r_cnt     <= '0;
      for (int i = 0; i < CORES; i++) begin
        r_lo[i] <= '0;
        r_hi[i] <= '0;
      end
    end else begin
      r_ack   <= w_grant ? w_gnt : '0;
      r_empty <= (w_grant && r_state == DONE) ?
                 w_gnt : '0;
      if (r_state == IDLE && start)
        r_next_lo <= C_LO;
      if (w_grant)
        r_ptr <= (w_idx == PW'(CORES - 1)) ?
                 '0 : w_idx + PW'(1);
      if (w_work) begin
        r_lo[w_idx] <= r_next_lo[ADDR_W-1:0];
        r_hi[w_idx] <= w_hi[ADDR_W-1:0];
        r_next_lo   <= w_hi + CW'(1);
        if (r_cnt != 8'hFF)
          r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < CORES; g++) begin : g_pack
    assign lo_out[slice_lsb(g, ADDR_W) +: ADDR_W] = r_lo[g];
    assign hi_out[slice_lsb(g, ADDR_W) +: ADDR_W] = r_hi[g];
  end

  assign ack           = r_ack;
  assign empty         = r_empty;
  assign busy          = (r_state == RUN);
  assign done          = (r_state == DONE);
  assign chunks_issued = r_cnt;

endmodule

// File: tb/tb_work_dispatcher.sv
// Scoreboard bench for work_dispatcher.
// Chunk list is precomputed at start; grants pop from it.
module tb_work_dispatcher;

  localparam int C   = 4;
  localparam int AW  = 8;
  localparam int RLO = 3;
  localparam int RHI = 255;
  localparam int CH  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [C-1:0]    req = '0;
  logic [C-1:0]    ack;
  logic [C*AW-1:0] lo_out;
  logic [C*AW-1:0] hi_out;
  logic [C-1:0]    empty;
  logic            busy;
  logic            done;
  logic [7:0]      chunks_issued;

  always #5 clk = ~clk;

  work_dispatcher #(
    .CORES    (C),
    .ADDR_W   (AW),
    .RANGE_LO (RLO),
    .RANGE_HI (RHI),
    .CHUNK    (CH)
  ) dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .req           (req),
    .ack           (ack),
    .lo_out        (lo_out),
    .hi_out        (hi_out),
    .empty         (empty),
    .busy          (busy),
    .done          (done),
    .chunks_issued (chunks_issued)
  );

  typedef struct {
    int core;
    int lo;
    int hi;
    bit emp;
  } exp_t;

  typedef struct {
    int lo;
    int hi;
  } chunk_t;

  exp_t   exp_q[$];
  chunk_t m_chunks[$];
  int     m_state;
  int     m_ptr;
  int     m_cnt;
  int     m_lo[C];
  int     m_hi[C];
  logic [C-1:0] m_ack;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference: m_state 0 idle, 1 running, 2 exhausted.
  always @(posedge clk or negedge rst_n) begin
    logic [C-1:0] elig;
    int win;
    chunk_t ck;
    exp_t e;
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_ack   = '0;
      for (int i = 0; i < C; i++) begin
        m_lo[i] = 0;
        m_hi[i] = 0;
      end
      m_chunks.delete();
      exp_q.delete();
    end else if (m_state == 0) begin
      if (start) begin
        m_state = 1;
        m_chunks.delete();
        for (int lo = RLO; lo <= RHI; lo += CH) begin
          ck.lo = lo;
          ck.hi = (lo + CH - 1 > RHI) ? RHI : lo + CH - 1;
          m_chunks.push_back(ck);
        end
      end
    end else begin
      elig = req & ~m_ack;
      win = -1;
      for (int k = 0; k < C; k++)
        if (win < 0 && elig[(m_ptr + k) % C])
          win = (m_ptr + k) % C;
      m_ack = '0;
      if (win >= 0) begin
        m_ack[win] = 1'b1;
        m_ptr = (win + 1) % C;
        e.core = win;
        if (m_state == 1) begin
          ck = m_chunks.pop_front();
          m_lo[win] = ck.lo;
          m_hi[win] = ck.hi;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
          if (m_chunks.size() == 0) m_state = 2;
          e.emp = 1'b0;
        end else begin
          e.emp = 1'b1;
        end
        e.lo = m_lo[win];
        e.hi = m_hi[win];
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic [C-1:0] ea;
    logic [C-1:0] ee;
    exp_t e;
    ea = '0;
    ee = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ea[e.core] = 1'b1;
      if (e.emp) ee[e.core] = 1'b1;
      chk("grant_lo", 64'(lo_out[e.core*AW +: AW]), 64'(e.lo));
      chk("grant_hi", 64'(hi_out[e.core*AW +: AW]), 64'(e.hi));
    end
    chk("ack", 64'(ack), 64'(ea));
    chk("empty", 64'(empty), 64'(ee));
    chk("busy", 64'(busy), 64'(m_state == 1));
    chk("done", 64'(done), 64'(m_state == 2));
    chk("chunks_issued", 64'(chunks_issued), 64'(m_cnt));
    for (int i = 0; i < C; i++) begin
      chk("lo_hold", 64'(lo_out[i*AW +: AW]), 64'(m_lo[i]));
      chk("hi_hold", 64'(hi_out[i*AW +: AW]), 64'(m_hi[i]));
    end
  end

  task automatic drive(
    input logic         s,
    input logic [C-1:0] r
  );
    start = s;
    req   = r;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ack"}, 64'(ack), 64'd0);
    chk({nm, "_empty"}, 64'(empty), 64'd0);
    chk({nm, "_lo"}, 64'(lo_out), 64'd0);
    chk({nm, "_hi"}, 64'(hi_out), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_cnt"}, 64'(chunks_issued), 64'd0);
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero("reset");
    rst_n = 1'b1;

    repeat (5) drive(1'b0, '1);
    drive(1'b1, '1);
    repeat (8) drive(1'b0, '1);
    repeat (6) drive(1'b0, 4'b0100);
    repeat (80) drive($urandom_range(0, 15) == 0,
                      4'($urandom));
    drive(1'b1, 4'b1111);
    repeat (4) drive(1'b0, 4'b0100);

    rst_n = 1'b0;
    #1;
    chk_zero("rst_pulse");
    drive(1'b0, '0);
    rst_n = 1'b1;
    drive(1'b1, '0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      drive(1'b0, 4'($urandom));
      if (ack != '0 && chunks_issued == 8'd5) hit = 1'b1;
    end
    chk("midrun_reached", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    drive(1'b0, '0);
    rst_n = 1'b1;

    drive(1'b1, '0);
    drive(1'b0, 4'b0001);
    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b0001);
    drive(1'b0, 4'b0000);
    repeat (120) drive($urandom_range(0, 15) == 0,
                       4'($urandom));
    repeat (3) drive(1'b0, '0);
    chk("final_state", 64'(m_state), 64'd2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
